// File: rtl/alu_host_module.sv
// ---------------------------------------------------------------------------
// alu_host_module
// Host-side sequencer for a FIFO-attached ALU. It accepts one request
// (opcode + two operands), pushes opcode, A and B into the TX FIFO, then
// pops exactly one result byte from the RX FIFO (first-word-fall-through).
//
// Optional feature macro: ALU_HOST_TIMEOUT_EN
//   defined   -> WAIT_RES gives up after TIMEOUT_CYCLES empty cycles and
//                flags o_timeout
//   undefined -> WAIT_RES waits indefinitely, o_timeout tied low
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      synchronous active-high reset
//   i_start      request pulse, sampled only in IDLE
//   i_op         opcode to send
//   i_dataA/B    operands
//   i_full       TX FIFO full
//   i_empty      RX FIFO empty
//   i_readdata   RX FIFO head (valid when i_empty = 0)
//   o_write      TX push strobe (combinational)
//   o_writedata  byte pushed when o_write = 1
//   o_read       RX pop strobe (combinational)
//   o_result     last received result byte
//   o_busy       high in every state except IDLE
//   o_done       one-cycle completion pulse
//   o_timeout    last transaction ended without a result
// ---------------------------------------------------------------------------
module alu_host_module #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_dataA,
    input  logic [NB_DATA-1:0] i_dataB,
    input  logic               i_full,
    input  logic               i_empty,
    input  logic [NB_DATA-1:0] i_readdata,
    output logic               o_write,
    output logic [NB_DATA-1:0] o_writedata,
    output logic               o_read,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_OP  = 3'd1,
        ST_SEND_A   = 3'd2,
        ST_SEND_B   = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic               timeout_hit_c;
    logic               accept_c;

    assign accept_c = (state == ST_IDLE) && i_start;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; SEND states advance only on an actual push
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (i_start) next_state = ST_SEND_OP;
            ST_SEND_OP:  if (o_write) next_state = ST_SEND_A;
            ST_SEND_A:   if (o_write) next_state = ST_SEND_B;
            ST_SEND_B:   if (o_write) next_state = ST_WAIT_RES;
            ST_WAIT_RES: if (o_read || timeout_hit_c) next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Output decode; strobes are masked during reset so an abandoned
    // transaction never pushes or pops in the cycle reset is applied
    always_comb begin
        o_write     = 1'b0;
        o_read      = 1'b0;
        o_writedata = '0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                o_busy = 1'b0;
            end
            ST_SEND_OP: begin
                o_write     = !i_full && !i_reset;
                o_writedata = NB_DATA'(op_q);
            end
            ST_SEND_A: begin
                o_write     = !i_full && !i_reset;
                o_writedata = data_a_q;
            end
            ST_SEND_B: begin
                o_write     = !i_full && !i_reset;
                o_writedata = data_b_q;
            end
            ST_WAIT_RES: begin
                o_read = !i_empty && !i_reset;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Request capture; operands only change on an accepted start
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_q     <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else if (accept_c) begin
            op_q     <= i_op;
            data_a_q <= i_dataA;
            data_b_q <= i_dataB;
        end
    end

    // Result capture; holds until the next pop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result <= '0;
        end else if (o_read) begin
            o_result <= i_readdata;
        end
    end

`ifdef ALU_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Expires on the TIMEOUT_CYCLES-th empty WAIT_RES cycle; a non-empty
    // RX FIFO on that cycle wins because the hit requires i_empty
    assign timeout_hit_c = (state == ST_WAIT_RES) && i_empty &&
                           (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter; idles at zero outside WAIT_RES so entry starts fresh
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT_RES) begin
            wait_cnt <= '0;
        end else if (i_empty) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Timeout flag; cleared when a new request is accepted
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_timeout <= 1'b0;
        end else if (accept_c) begin
            o_timeout <= 1'b0;
        end else if (timeout_hit_c) begin
            o_timeout <= 1'b1;
        end
    end
`else
    // No timeout hardware; the parameter is still referenced so both builds
    // share one parameter list without an unused-parameter report
    assign timeout_hit_c = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_host_module.sv
// ---------------------------------------------------------------------------
// tb_alu_host_module
// Directed bench with a scoreboard: stimulus pushes expected TX pushes and
// completions (with the cycle they must occur in) into a queue; a negedge
// monitor pops and compares whenever the DUT pushes or signals done.
// The RX FIFO is modelled as a queue; ALU_HOST_TIMEOUT_EN adds timeout cases.
// ---------------------------------------------------------------------------
module tb_alu_host_module;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_start;
    logic [NB_OP-1:0]   i_op;
    logic [NB_DATA-1:0] i_dataA;
    logic [NB_DATA-1:0] i_dataB;
    logic               i_full;
    logic               i_empty;
    logic [NB_DATA-1:0] i_readdata;
    logic               o_write;
    logic [NB_DATA-1:0] o_writedata;
    logic               o_read;
    logic [NB_DATA-1:0] o_result;
    logic               o_busy;
    logic               o_done;
    logic               o_timeout;

    alu_host_module #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_op(i_op),
        .i_dataA(i_dataA),
        .i_dataB(i_dataB),
        .i_full(i_full),
        .i_empty(i_empty),
        .i_readdata(i_readdata),
        .o_write(o_write),
        .o_writedata(o_writedata),
        .o_read(o_read),
        .o_result(o_result),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int kind;   // 0 = TX push, 1 = completion
        int data;   // pushed byte or result byte
        int tmo;    // expected o_timeout at completion
        int cyc;    // cycle in which the event must appear
    } exp_t;

    exp_t exp_q[$];
    logic [NB_DATA-1:0] rx_q[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int read_cnt = 0;
    logic pop_req = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rx_refresh();
        i_empty    = (rx_q.size() == 0);
        i_readdata = (rx_q.size() != 0) ? rx_q[0] : '0;
    endtask

    task automatic rx_push(input logic [NB_DATA-1:0] d);
        rx_q.push_back(d);
        rx_refresh();
    endtask

    // RX FIFO pop, applied just after the edge the DUT consumed the head on
    always @(posedge i_clk) begin
        if (pop_req) begin
            #1;
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            pop_req = 1'b0;
            rx_refresh();
        end
    end

    // Monitor / scoreboard
    always @(negedge i_clk) begin
        exp_t e;
        if (o_read) begin
            read_cnt++;
            pop_req = 1'b1;
        end
        if (o_write) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_push actual=0x%0h expected=none (cycle %0d)", o_writedata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("push_kind", 0, e.kind);
                chk("push_data", int'(o_writedata), e.data);
                chk("push_cycle", cyc, e.cyc);
            end
        end
        if (o_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", 1, e.kind);
                chk("done_result", int'(o_result), e.data);
                chk("done_timeout", int'(o_timeout), e.tmo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic exp_w(input int d, input int c);
        exp_t e;
        e.kind = 0; e.data = d; e.tmo = 0; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_d(input int d, input int t, input int c);
        exp_t e;
        e.kind = 1; e.data = d; e.tmo = t; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    // Pulse start for one cycle; returns the cycle the pulse was sampled in
    task automatic issue(input logic [NB_OP-1:0] op, input logic [NB_DATA-1:0] a,
                         input logic [NB_DATA-1:0] b, output int s);
        i_op = op; i_dataA = a; i_dataB = b; i_start = 1'b1;
        s = cyc;
        step();
        i_start = 1'b0;
    endtask

    // Wait (bounded) for a completion, then one more cycle into IDLE
    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 60) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, int'(done_cnt != d0), 1);
        step();
        chk({name, "_idle_busy"}, int'(o_busy), 0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int r0;

        i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_dataA = '0; i_dataB = '0;
        i_full = 1'b0;
        rx_refresh();
        repeat (3) step();
        i_reset = 1'b0;
        step();

        // Reset state
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_timeout", int'(o_timeout), 0);
        chk("rst_result", int'(o_result), 0);
        chk("rst_write", int'(o_write), 0);
        chk("rst_read", int'(o_read), 0);
        chk("rst_writedata", int'(o_writedata), 0);

        // Basic transaction: three consecutive pushes, one pop
        r0 = read_cnt;
        rx_push(8'h08);
        issue(6'h20, 8'h05, 8'h03, s);
        exp_w(8'h20, s + 1); exp_w(8'h05, s + 2); exp_w(8'h03, s + 3);
        exp_d(8'h08, 0, s + 5);
        wait_done("basic");
        chk("basic_pops", read_cnt - r0, 1);

        // TX FIFO full for 5 cycles while in SEND_A
        rx_push(8'h44);
        issue(6'h20, 8'h05, 8'h03, s);
        exp_w(8'h20, s + 1); exp_w(8'h05, s + 7); exp_w(8'h03, s + 8);
        exp_d(8'h44, 0, s + 10);
        wait_cyc(s + 2); i_full = 1'b1;
        wait_cyc(s + 7); i_full = 1'b0;
        wait_done("stall");

        // Start re-pulsed during WAIT_RES is ignored
        issue(6'h21, 8'h07, 8'h09, s);
        exp_w(8'h21, s + 1); exp_w(8'h07, s + 2); exp_w(8'h09, s + 3);
        exp_d(8'h5A, 0, s + 9);
        wait_cyc(s + 5);
        i_op = 6'h22; i_dataA = 8'hAA; i_dataB = 8'hBB; i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_cyc(s + 8); rx_push(8'h5A);
        wait_done("restart");

        // Two RX bytes: only the head is consumed
        r0 = read_cnt;
        rx_push(8'h11); rx_push(8'h22);
        issue(6'h03, 8'h01, 8'h02, s);
        exp_w(8'h03, s + 1); exp_w(8'h01, s + 2); exp_w(8'h02, s + 3);
        exp_d(8'h11, 0, s + 5);
        wait_done("two_rx");
        chk("two_rx_pops", read_cnt - r0, 1);
        chk("two_rx_left", rx_q.size(), 1);
        chk("two_rx_head", int'(i_readdata), 8'h22);
        rx_q.delete(); rx_refresh();

        // Reset in SEND_A abandons the transaction
        issue(6'h20, 8'h05, 8'h03, s);
        exp_w(8'h20, s + 1);
        wait_cyc(s + 2); i_reset = 1'b1;
        wait_cyc(s + 3); i_reset = 1'b0;
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_result", int'(o_result), 0);
        chk("mid_rst_done", int'(o_done), 0);
        chk("mid_rst_write", int'(o_write), 0);
        chk("mid_rst_timeout", int'(o_timeout), 0);
        chk("mid_rst_queue", exp_q.size(), 0);
        rx_push(8'h10);
        issue(6'h20, 8'hFF, 8'h01, s);
        exp_w(8'h20, s + 1); exp_w(8'hFF, s + 2); exp_w(8'h01, s + 3);
        exp_d(8'h10, 0, s + 5);
        wait_done("post_rst");

`ifdef ALU_HOST_TIMEOUT_EN
        // Empty RX: give up after 16 WAIT_RES cycles, result unchanged
        r0 = read_cnt;
        issue(6'h02, 8'h10, 8'h20, s);
        exp_w(8'h02, s + 1); exp_w(8'h10, s + 2); exp_w(8'h20, s + 3);
        exp_d(8'h10, 1, s + 20);
        wait_done("timeout");
        chk("timeout_pops", read_cnt - r0, 0);
        chk("timeout_flag_hold", int'(o_timeout), 1);

        // Data arriving on the expiry cycle wins over the timeout
        issue(6'h04, 8'h30, 8'h40, s);
        exp_w(8'h04, s + 1); exp_w(8'h30, s + 2); exp_w(8'h40, s + 3);
        exp_d(8'h77, 0, s + 20);
        wait_cyc(s + 19); rx_push(8'h77);
        wait_done("tie");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_host_module.md
ALU_HOST_MODULE -- requirements
Module: alu_host_module

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, byte width of FIFO data and operands.
REQ-002 SHALL have parameter NB_OP, default 6, opcode width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, result-wait limit in clocks (used only with ALU_HOST_TIMEOUT_EN).
REQ-004 i_clk  in  1  clock; all logic on rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  request pulse; sampled only in IDLE.
REQ-007 i_op  in  NB_OP  opcode to send.
REQ-008 i_dataA  in  NB_DATA  operand A.
REQ-009 i_dataB  in  NB_DATA  operand B.
REQ-010 i_full  in  1  TX FIFO full.
REQ-011 i_empty  in  1  RX FIFO empty.
REQ-012 i_readdata  in  NB_DATA  RX FIFO head, valid whenever i_empty=0 (first-word-fall-through).
REQ-013 o_write  out  1  TX FIFO push strobe.
REQ-014 o_writedata  out  NB_DATA  byte pushed when o_write=1.
REQ-015 o_read  out  1  RX FIFO pop strobe.
REQ-016 o_result  out  NB_DATA  last received result byte.
REQ-017 o_busy  out  1  high in every state except IDLE.
REQ-018 o_done  out  1  one-cycle completion pulse.
REQ-019 o_timeout  out  1  last transaction ended without a result.

Function
REQ-020 States SHALL be IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES, DONE.
REQ-021 IDLE with i_start=1: latch i_op, i_dataA, i_dataB, clear o_timeout, go SEND_OP next cycle.
REQ-022 i_start outside IDLE SHALL be ignored; latched operands SHALL not change.
REQ-023 o_write SHALL be combinational: 1 iff state is SEND_OP/SEND_A/SEND_B and i_full=0.
REQ-024 o_writedata SHALL be {zero-pad, op} in SEND_OP, A in SEND_A, B in SEND_B, 0 otherwise.
REQ-025 Each SEND_x SHALL advance (SEND_OP->SEND_A->SEND_B->WAIT_RES) only on a cycle with o_write=1; i_full=1 holds state, no push.
REQ-026 With i_full=0 throughout, the three bytes SHALL be pushed on three consecutive cycles, first push one cycle after i_start.
REQ-027 o_read SHALL be combinational: 1 iff state=WAIT_RES and i_empty=0.
REQ-028 On an o_read cycle, o_result SHALL load i_readdata and state SHALL go DONE.
REQ-029 DONE SHALL assert o_done for exactly one cycle, then go IDLE; new i_start accepted from that IDLE cycle.
REQ-030 Exactly one byte SHALL be popped per transaction; extra RX bytes remain in FIFO.
REQ-031 o_result SHALL hold its value until next successful read.
REQ-032 Undefined state encodings SHALL return to IDLE with strobes low.

Reset
REQ-033 Reset SHALL force IDLE, o_result=0, o_timeout=0, o_done=0, o_busy=0, latched operands=0, timeout counter=0.
REQ-034 Reset mid-transaction SHALL abandon it without any further push or pop; o_write/o_read low in the cycle after reset asserts.

Configuration
REQ-035 Macro ALU_HOST_TIMEOUT_EN defined: counter clears on WAIT_RES entry, increments each WAIT_RES cycle with i_empty=1; on reaching TIMEOUT_CYCLES go DONE with o_timeout=1, o_result unchanged, no pop.
REQ-036 Pop and timeout on the same cycle SHALL favor the pop (o_timeout=0).
REQ-037 Macro ALU_HOST_TIMEOUT_EN undefined: no counter, WAIT_RES waits indefinitely, o_timeout tied 0.

Verification
REQ-038 op=0x20, A=0x05, B=0x03, i_full=0, RX supplies 0x08 -> pushes 0x20,0x05,0x03 on cycles 1-3, one pop, o_result=0x08, single o_done.
REQ-039 i_full=1 for 5 cycles while in SEND_A -> no push during stall, 0x05 pushed first cycle i_full=0, byte order intact.
REQ-040 i_start re-pulsed with op=0x22 during WAIT_RES -> ignored; only original three bytes sent.
REQ-041 ALU_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, RX empty -> o_done and o_timeout=1 after 16 WAIT_RES cycles, o_read never 1.
REQ-042 i_reset asserted in SEND_A -> no further push, IDLE, all outputs at reset values; next transaction A=0xFF, B=0x01 completes normally.
REQ-043 RX holds two bytes 0x11,0x22 -> o_result=0x11, exactly one pop, 0x22 remains.
